spi_arb_master: RTL and testbench

- Shares the single front-panel SPI path (the demux_spi select plus sck/cs/mosi/miso) between the five FMC SPI slaves: DAC1, DAC2, LMK04828, SYNT1 and SYNT2.
- Per-slave requesters (init FSMs, register bridge) post word transfers. The block arbitrates between them and drives mux_spi.
- It generates mode-0 SPI framing, captures miso, and returns the read-back word to the requester that was granted.
- It sits between the control logic and the demux_spi s_* port.

---
 rtl/spi_arb_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_arb_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arb_master.sv
// spi_arb_master: shares one mode-0 SPI path between M_COUNT requesters.
// Requests are arbitrated, framed with CS guard time, and the captured MISO word
// is returned to the granted port.
// Optional build macro SPI_ARB_FIXED_PRIO_EN: lowest-index valid port always wins
// and no round-robin pointer exists; otherwise round-robin arbitration is used.
module spi_arb_master #(
  parameter int M_COUNT  = 5,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 6,
  parameter int CLK_DIV  = 4,
  parameter int CS_GUARD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [M_COUNT-1:0]        req_valid,
  output logic [M_COUNT-1:0]        req_ready,
  input  logic [M_COUNT*DATA_W-1:0] req_data,
  input  logic [M_COUNT*LEN_W-1:0]  req_len,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_port,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [2:0]                mux_spi,
  output logic                      spi_sck,
  output logic                      spi_cs,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0]   DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'(CS_GUARD - 1);
  localparam logic [LEN_W:0]     MAX_LEN    = (LEN_W+1)'(DATA_W);
  localparam logic [M_COUNT-1:0] PORT0      = M_COUNT'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SETUP,
    S_LEAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    bits_q, bits_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          mux_q, mux_d;
  logic [2:0]          rsp_port_q, rsp_port_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;

  logic                win_found;
  logic [2:0]          win_idx;
  logic [DATA_W-1:0]   win_data;
  logic [LEN_W-1:0]    win_len;
  logic                win_len_ok;
  logic                div_end;
  logic                guard_end;
  logic                cs_low;

`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [2:0]          last_q, last_d;
`endif

  // Pick the winning port among the currently valid requests
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int p = M_COUNT - 1; p >= 0; p--) begin
      if (req_valid[p]) begin
        win_found = 1'b1;
        win_idx   = 3'(p);
      end
    end
`else
    for (int p = 0; p < M_COUNT; p++) begin
      if (!win_found && req_valid[p] && (3'(p) > last_q)) begin
        win_found = 1'b1;
        win_idx   = 3'(p);
      end
    end
    for (int p = 0; p < M_COUNT; p++) begin
      if (!win_found && req_valid[p] && (3'(p) <= last_q)) begin
        win_found = 1'b1;
        win_idx   = 3'(p);
      end
    end
`endif
  end

  // Route the winner's data word and length out of the flattened request buses
  always_comb begin
    win_data = '0;
    win_len  = '0;
    for (int p = 0; p < M_COUNT; p++) begin
      if (3'(p) == win_idx) begin
        win_data = req_data[p*DATA_W +: DATA_W];
        win_len  = req_len[p*LEN_W +: LEN_W];
      end
    end
  end

  assign win_len_ok = (win_len != '0) && ({1'b0, win_len} <= MAX_LEN);
  assign div_end    = (cnt_q == DIV_LAST);
  assign guard_end  = (cnt_q == GUARD_LAST);
  assign cs_low     = (state_q == S_LEAD) || (state_q == S_SHIFT_HI) ||
                      (state_q == S_SHIFT_LO) || (state_q == S_TRAIL);

  assign req_ready = (state_q == S_ARB && win_found) ? (PORT0 << win_idx) : '0;
  assign busy      = (state_q == S_ARB) ? win_found : (state_q != S_IDLE);
  assign spi_cs    = ~cs_low;
  assign spi_sck   = (state_q == S_SHIFT_HI);
  assign spi_mosi  = cs_low & shift_q[DATA_W-1];
  assign mux_spi   = mux_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_port  = rsp_port_q;
  assign rsp_data  = rsp_data_q;

  // Next-state logic: arbitration, frame phase sequencing, shift and capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bits_d      = bits_q;
    shift_d     = shift_q;
    cap_d       = cap_q;
    idx_d       = idx_q;
    mux_d       = mux_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_port_d  = rsp_port_q;
    rsp_data_d  = rsp_data_q;
`ifndef SPI_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|req_valid) state_d = S_ARB;
      end
      S_ARB: begin
        cnt_d = '0;
        if (!win_found) begin
          state_d = S_IDLE;
        end else begin
          idx_d = win_idx;
`ifndef SPI_ARB_FIXED_PRIO_EN
          last_d = win_idx;
`endif
          if (win_len_ok) begin
            shift_d = win_data;
            bits_d  = win_len;
            cap_d   = '0;
            mux_d   = win_idx;
            state_d = S_SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_port_d  = win_idx;
            rsp_data_d  = '0;
            state_d     = S_IDLE;
          end
        end
      end
      S_SETUP: begin
        if (guard_end) begin
          cnt_d   = '0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (div_end) begin
          cnt_d   = '0;
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (cnt_q == '0) cap_d = {cap_q[DATA_W-2:0], spi_miso};
        if (div_end) begin
          cnt_d = '0;
          if (bits_q == LEN_W'(1)) begin
            state_d = S_TRAIL;
          end else begin
            bits_d  = bits_q - LEN_W'(1);
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_SHIFT_LO: begin
        if (div_end) begin
          cnt_d   = '0;
          state_d = S_SHIFT_HI;
        end
      end
      S_TRAIL: begin
        if (div_end) begin
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_port_d  = idx_q;
          rsp_data_d  = cap_q;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (guard_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      shift_q     <= '0;
      cap_q       <= '0;
      idx_q       <= '0;
      mux_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_port_q  <= '0;
      rsp_data_q  <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      last_q      <= 3'(M_COUNT - 1);
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      mux_q       <= mux_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_port_q  <= rsp_port_d;
      rsp_data_q  <= rsp_data_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_arb_master.sv
// Directed testbench for spi_arb_master: framing, capture, arbitration order,
// illegal lengths, mid-frame reset and inter-frame spacing.
module tb_spi_arb_master;

  logic          clk;
  logic          rst;
  logic [4:0]    req_valid;
  logic [4:0]    req_ready;
  logic [159:0]  req_data;
  logic [29:0]   req_len;
  logic          rsp_valid;
  logic [2:0]    rsp_port;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          busy;
  logic [2:0]    mux_spi;
  logic          spi_sck;
  logic          spi_cs;
  logic          spi_mosi;
  logic          spi_miso;

  int n_checks = 0;
  int n_errors = 0;

  // observation state kept by the per-cycle monitor inside tick()
  int          cyc = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b0;
  logic        prev_busy = 1'b0;
  logic [2:0]  prev_mux = 3'd0;
  logic [2:0]  prev2_mux = 3'd0;
  logic [4:0]  drop_mask = '0;
  logic        hold_valid = 1'b0;
  int          grant_cnt = 0;
  int          grant_cyc = 0;
  int          grant_port = 0;
  int          grant_log [8];
  int          grant_log_n = 0;
  int          frames = 0;
  int          fall_cyc = 0;
  int          rise_cyc = 0;
  int          last_gap = 0;
  int          last_low = 0;
  int          cs_low_cnt = 0;
  int          cs_high_cnt = 0;
  int          rise_cnt = 0;
  logic [31:0] mosi_cap = '0;
  logic [2:0]  mux_at_fall = '0;
  logic [2:0]  mux_pre1 = '0;
  logic [2:0]  mux_pre2 = '0;
  int          mux_bad = 0;
  logic [31:0] miso_pat = '0;
  int          miso_len = 0;
  int          miso_idx = 0;
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  logic [2:0]  rsp_port_s = '0;
  logic [31:0] rsp_data_s = '0;
  logic        rsp_err_s = 1'b0;
  int          busy_fall_cyc = 0;

  spi_arb_master #(
    .M_COUNT(5), .DATA_W(32), .LEN_W(6), .CLK_DIV(4), .CS_GUARD(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mux_spi(mux_spi),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [31:0] data, input logic [5:0] len);
    req_data[port*32 +: 32] = data;
    req_len[port*6 +: 6]    = len;
    req_valid[port]         = 1'b1;
  endtask

  // one clock cycle: sample DUT at the falling edge, play the SPI slave, record events
  task automatic tick();
    @(negedge clk);
    cyc++;
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
    if (req_ready != 5'b0) begin
      grant_cnt++;
      grant_cyc = cyc;
      for (int p = 0; p < 5; p++) if (req_ready[p]) grant_port = p;
      if (grant_log_n < 8) begin
        grant_log[grant_log_n] = grant_port;
        grant_log_n++;
      end
      if (!hold_valid) drop_mask = req_ready;
    end
    if (!spi_cs && prev_cs) begin
      frames++;
      fall_cyc    = cyc;
      last_gap    = cs_high_cnt;
      cs_low_cnt  = 0;
      mosi_cap    = '0;
      rise_cnt    = 0;
      mux_at_fall = mux_spi;
      mux_pre1    = prev_mux;
      mux_pre2    = prev2_mux;
      miso_idx    = miso_len - 1;
      spi_miso    = (miso_idx >= 0) ? miso_pat[miso_idx] : 1'b0;
    end
    if (spi_cs && !prev_cs) begin
      rise_cyc    = cyc;
      last_low    = cs_low_cnt;
      cs_high_cnt = 0;
    end
    if (spi_cs) cs_high_cnt++;
    else cs_low_cnt++;
    if (!spi_cs && spi_sck && !prev_sck) begin
      mosi_cap = {mosi_cap[30:0], spi_mosi};
      rise_cnt++;
    end
    if (!spi_cs && !spi_sck && prev_sck) begin
      miso_idx--;
      spi_miso = (miso_idx >= 0) ? miso_pat[miso_idx] : 1'b0;
    end
    if (!spi_cs && (mux_spi != prev_mux)) mux_bad++;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc    = cyc;
      rsp_port_s = rsp_port;
      rsp_data_s = rsp_data;
      rsp_err_s  = rsp_err;
    end
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    prev2_mux = prev_mux;
    prev_mux  = mux_spi;
    prev_cs   = spi_cs;
    prev_sck  = spi_sck;
    prev_busy = busy;
  endtask

  task automatic waitRsp(input string tag, input int target, input int budget);
    int n = 0;
    while (rsp_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(rsp_cnt), 64'(target));
  endtask

  initial begin
    int r0;
    int f0;
    int g0;
    int n;
    logic [2:0] mux0;
    int exp_order [5];
`ifdef SPI_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 2, 4, 0, 2};
`endif
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_len = '0;
    spi_miso = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset values
    checkOutput("rst_cs", spi_cs, 1);
    checkOutput("rst_sck", spi_sck, 0);
    checkOutput("rst_mosi", spi_mosi, 0);
    checkOutput("rst_mux", mux_spi, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_port", rsp_port, 0);
    checkOutput("rst_busy", busy, 0);

    // port 2, 24-bit frame
    r0 = rsp_cnt;
    miso_pat = '0;
    miso_len = 24;
    applyStimulus(2, 32'hABCDEF00, 6'd24);
    waitRsp("t1_rsp", r0 + 1, 400);
    repeat (4) tick();
    checkOutput("t1_setup_cycles", 64'(fall_cyc - grant_cyc), 3);
    checkOutput("t1_mux_pre1", mux_pre1, 2);
    checkOutput("t1_mux_pre2", mux_pre2, 2);
    checkOutput("t1_cs_low", 64'(last_low), 196);
    checkOutput("t1_sck_rises", 64'(rise_cnt), 24);
    checkOutput("t1_mosi", mosi_cap, 32'h00ABCDEF);
    checkOutput("t1_rsp_port", rsp_port_s, 2);
    checkOutput("t1_rsp_err", rsp_err_s, 0);
    checkOutput("t1_rsp_with_cs_rise", 64'(rsp_cyc - rise_cyc), 0);
    checkOutput("t1_busy_gap", 64'(busy_fall_cyc - rise_cyc), 2);

    // port 0, 16-bit frame with MISO read-back
    r0 = rsp_cnt;
    miso_pat = 32'h00005A3C;
    miso_len = 16;
    applyStimulus(0, 32'h12340000, 6'd16);
    waitRsp("t2_rsp", r0 + 1, 400);
    repeat (4) tick();
    checkOutput("t2_rsp_data", rsp_data_s, 32'h00005A3C);
    checkOutput("t2_rsp_port", rsp_port_s, 0);
    checkOutput("t2_mosi", mosi_cap, 32'h00001234);
    checkOutput("t2_cs_low", 64'(last_low), 132);

    // illegal lengths: port 3 len 0, then port 4 len 33
    r0 = rsp_cnt;
    f0 = frames;
    mux0 = mux_spi;
    applyStimulus(3, 32'hFFFFFFFF, 6'd0);
    waitRsp("t3_rsp", r0 + 1, 20);
    checkOutput("t3_latency", 64'(rsp_cyc - grant_cyc), 1);
    checkOutput("t3_rsp_err", rsp_err_s, 1);
    checkOutput("t3_rsp_port", rsp_port_s, 3);
    checkOutput("t3_rsp_data", rsp_data_s, 0);
    applyStimulus(4, 32'hFFFFFFFF, 6'd33);
    waitRsp("t4_rsp", r0 + 2, 20);
    repeat (3) tick();
    checkOutput("t4_latency", 64'(rsp_cyc - grant_cyc), 1);
    checkOutput("t4_rsp_err", rsp_err_s, 1);
    checkOutput("t4_rsp_port", rsp_port_s, 4);
    checkOutput("t34_no_frame", 64'(frames), 64'(f0));
    checkOutput("t34_mux_held", mux_spi, mux0);
    checkOutput("t34_rsp_count", 64'(rsp_cnt), 64'(r0 + 2));

    // simultaneous requests on ports 0, 2, 4 held continuously
    r0 = rsp_cnt;
    miso_len = 1;
    hold_valid = 1'b1;
    grant_log_n = 0;
    applyStimulus(0, 32'h80000000, 6'd1);
    applyStimulus(2, 32'h80000000, 6'd1);
    applyStimulus(4, 32'h80000000, 6'd1);
    n = 0;
    while (grant_log_n < 5 && n < 400) begin
      tick();
      n++;
    end
    tick();
    req_valid = '0;
    hold_valid = 1'b0;
    checkOutput("rr_grants", 64'(grant_log_n), 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    waitRsp("rr_rsp", r0 + 5, 200);
    repeat (4) tick();

    // reset in the middle of a 32-bit port-1 frame
    r0 = rsp_cnt;
    miso_len = 32;
    miso_pat = 32'h0F0F0F0F;
    applyStimulus(1, 32'hDEADBEEF, 6'd32);
    n = 0;
    while (!(rise_cnt == 10 && !spi_cs) && n < 500) begin
      tick();
      n++;
    end
    checkOutput("rst_mid_reach", 64'(rise_cnt), 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_cs", spi_cs, 1);
    checkOutput("rst_mid_sck", spi_sck, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_rsp_valid", rsp_valid, 0);
    checkOutput("rst_mid_mux", mux_spi, 0);
    repeat (40) tick();
    checkOutput("rst_mid_no_rsp", 64'(rsp_cnt), 64'(r0));

    // new request after the reset is served normally
    miso_pat = 32'h0000003C;
    miso_len = 8;
    applyStimulus(1, 32'hA5000000, 6'd8);
    waitRsp("post_rst_rsp", r0 + 1, 300);
    repeat (4) tick();
    checkOutput("post_rst_data", rsp_data_s, 32'h0000003C);
    checkOutput("post_rst_port", rsp_port_s, 1);
    checkOutput("post_rst_mosi", mosi_cap, 32'h000000A5);
    checkOutput("post_rst_cs_low", 64'(last_low), 68);

    // port 1 then port 4, both 32 bits: spacing and mux stability
    r0 = rsp_cnt;
    f0 = frames;
    g0 = grant_cnt;
    mux_bad = 0;
    miso_pat = 32'hCAFEF00D;
    miso_len = 32;
    applyStimulus(1, 32'h12345678, 6'd32);
    n = 0;
    while (grant_cnt == g0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("t6_grant1", 64'(grant_port), 1);
    applyStimulus(4, 32'h87654321, 6'd32);
    waitRsp("t6_rsp", r0 + 2, 1200);
    repeat (4) tick();
    checkOutput("t6_frames", 64'(frames - f0), 2);
    checkOutput("t6_gap_min", 64'(last_gap >= 5), 1);
    checkOutput("t6_mux_second", mux_at_fall, 4);
    checkOutput("t6_mux_stable", 64'(mux_bad), 0);
    checkOutput("t6_rsp_port", rsp_port_s, 4);
    checkOutput("t6_rsp_data", rsp_data_s, 32'hCAFEF00D);
    checkOutput("t6_mosi", mosi_cap, 32'h87654321);
    checkOutput("t6_cs_low", 64'(last_low), 260);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
